// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM states,
// frame geometry and line levels.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam int unsigned DATA_BITS = 8;
    localparam logic        LINE_IDLE = 1'b1;
    localparam logic        START_LVL = 1'b0;

endpackage

// File: rtl/baud_gen.sv
// Bit-period timer: counts clk cycles within one UART bit and pulses
// bit_done on the last cycle of each bit; restart re-aligns to a new bit.
module baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic bit_done
);

    localparam int unsigned   CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    assign bit_done = (cnt_q == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO read-side consumer: pops one byte per frame and serialises it as
// start bit, 8 data bits LSB first, optional even parity, one stop bit.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_en,
    input  logic       EMP,
    output logic       read_req,
    input  logic [7:0] read_data,
    output logic       tx,
    output logic       busy
);

    state_e                 state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic                   parity_q, parity_d;
    logic                   tx_q, tx_d;
    logic                   read_req_q, read_req_d;
    logic                   busy_q, busy_d;
    logic                   restart;
    logic                   bit_done;

    // Every state change restarts the bit timer, so each state's first
    // cycle is cycle 0 of its bit period.
    assign restart = (state_d != state_q);

    baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .bit_done(bit_done)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;

        case (state_q)
            IDLE: begin
                if (tx_en && !EMP) begin
                    state_d = FETCH;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                shift_d  = read_data;
                parity_d = ^read_data;
                state_d  = START;
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end else begin
                        shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        read_req_d = (state_d == FETCH);
        busy_d     = (state_d != IDLE);
        case (state_d)
            START:   tx_d = START_LVL;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            parity_q   <= 1'b0;
            tx_q       <= LINE_IDLE;
            read_req_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            read_req_q <= read_req_d;
            busy_q     <= busy_d;
        end
    end

    assign read_req = read_req_q;
    assign tx       = tx_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a no-parity and an even-parity instance, each fed
// by a queue-based FIFO model and checked by a cycle-accurate line decoder.
module tb_fifo_uart_tx;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_en0, tx_en1;
    logic       emp0, emp1;
    logic       rr0, rr1;
    logic [7:0] rd0 = '0;
    logic [7:0] rd1 = '0;
    logic       tx0, tx1;
    logic       busy0, busy1;

    logic [7:0] fifo0[$];
    logic [7:0] fifo1[$];
    logic [7:0] sb0[$];
    logic [7:0] sb1[$];

    int checks = 0;
    int errors = 0;
    int rr_cnt0 = 0;
    int rr_cnt1 = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b0)) dut0 (
        .clk(clk), .reset(rst_n), .tx_en(tx_en0), .EMP(emp0),
        .read_req(rr0), .read_data(rd0), .tx(tx0), .busy(busy0)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1)) dut1 (
        .clk(clk), .reset(rst_n), .tx_en(tx_en1), .EMP(emp1),
        .read_req(rr1), .read_data(rd1), .tx(tx1), .busy(busy1)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic txs(int sel);
        return (sel != 0) ? tx1 : tx0;
    endfunction

    // FIFO models: empty flag settles at the falling edge, data follows a pop.
    always @(negedge clk) begin
        emp0 = (fifo0.size() == 0);
        emp1 = (fifo1.size() == 0);
    end

    always @(posedge clk) begin
        if (rr0 === 1'b1) begin
            rr_cnt0++;
            chk("pop_nonempty0", 32'(fifo0.size() != 0), 1);
            if (fifo0.size() != 0) rd0 <= fifo0.pop_front();
        end
        if (rr1 === 1'b1) begin
            rr_cnt1++;
            chk("pop_nonempty1", 32'(fifo1.size() != 0), 1);
            if (fifo1.size() != 0) rd1 <= fifo1.pop_front();
        end
    end

    task automatic push(input int sel, input logic [7:0] b, input bit track);
        if (sel != 0) begin
            fifo1.push_back(b);
            if (track) sb1.push_back(b);
        end else begin
            fifo0.push_back(b);
            if (track) sb0.push_back(b);
        end
    endtask

    // Decode one frame; samples every cycle so any bit-length error shows up.
    task automatic recv(input int sel, input bit exp_par, input bit started);
        int         nb;
        int         bad;
        bit         got;
        logic [43:0] lv;
        logic [10:0] bits;
        logic [7:0]  exp_b;
        nb  = (sel != 0) ? 11 : 10;
        got = started;
        lv  = '1;
        for (int t = 0; t < 400 && !got; t++) begin
            @(negedge clk);
            if (txs(sel) == 1'b0) got = 1'b1;
        end
        chk("rx_start_seen", 32'(got), 1);
        if (!got) return;
        lv[0] = txs(sel);
        for (int c = 1; c < nb * C; c++) begin
            @(negedge clk);
            lv[c] = txs(sel);
        end
        bits = '1;
        bad  = 0;
        for (int b = 0; b < nb; b++) bits[b] = lv[b * C + C / 2];
        for (int c = 0; c < nb * C; c++) if (lv[c] !== bits[c / C]) bad++;
        exp_b = 'x;
        if (sel != 0) begin
            chk("rx_sb_nonempty", 32'(sb1.size() != 0), 1);
            if (sb1.size() != 0) exp_b = sb1.pop_front();
        end else begin
            chk("rx_sb_nonempty", 32'(sb0.size() != 0), 1);
            if (sb0.size() != 0) exp_b = sb0.pop_front();
        end
        chk("rx_byte", 32'(bits[8:1]), 32'(exp_b));
        chk("rx_framing", {29'd0, (bad == 0), bits[0], bits[nb-1]}, 32'b101);
        if (sel != 0) chk("rx_parity", 32'(bits[9]), 32'(exp_par));
    endtask

    // Count idle-high cycles until the next start bit (which it consumes).
    task automatic gap(input int sel, input int exp);
        int n;
        bit low;
        n   = 0;
        low = 1'b0;
        for (int t = 0; t < 200 && !low; t++) begin
            @(negedge clk);
            if (txs(sel) == 1'b0) low = 1'b1;
            else n++;
        end
        chk("inter_frame_gap", n, exp);
    endtask

    typedef struct {
        int         sel;
        logic [7:0] data;
        bit         par;
    } vec_t;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t        vt[9];
        logic [9:0]  fr;
        logic        exp_tx;
        int          base;
        int          n;
        int          k;
        bit          seen;

        vt[0] = '{1, 8'hA5, 1'b0};
        vt[1] = '{1, 8'h01, 1'b1};
        vt[2] = '{1, 8'hFF, 1'b0};
        vt[3] = '{1, 8'h80, 1'b1};
        vt[4] = '{1, 8'h3C, 1'b0};
        vt[5] = '{0, 8'h00, 1'b0};
        vt[6] = '{0, 8'hFF, 1'b0};
        vt[7] = '{0, 8'h55, 1'b0};
        vt[8] = '{0, 8'h80, 1'b0};

        rst_n  = 1'b0;
        tx_en0 = 1'b1;
        tx_en1 = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_dut0", {29'd0, tx0, rr0, busy0}, 32'b100);
        chk("reset_dut1", {29'd0, tx1, rr1, busy1}, 32'b100);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Exact waveform of one 0xA5 frame without parity.
        fr = {1'b1, 8'hA5, 1'b0};
        base = rr_cnt0;
        @(posedge clk); #1;
        push(0, 8'hA5, 1'b0);
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            exp_tx = (i >= 3 && i < 43) ? fr[(i - 3) / C] : 1'b1;
            chk("t1_wave", {29'd0, rr0, busy0, tx0},
                {29'd0, (i == 1), (i >= 1 && i <= 42), exp_tx});
        end
        chk("t1_pops", rr_cnt0 - base, 1);

        // Empty FIFO with tx_en high: nothing happens.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("t3_idle", {29'd0, rr0, tx0, busy0}, 32'b010);
        end

        // Table: back-to-back bursts per instance.
        for (int s = 1; s >= 0; s--) begin
            n = 0;
            k = 0;
            @(posedge clk); #1;
            foreach (vt[i]) if (vt[i].sel == s) begin
                push(s, vt[i].data, 1'b1);
                n++;
            end
            foreach (vt[i]) if (vt[i].sel == s) begin
                recv(s, vt[i].par, k != 0);
                k++;
                if (k < n) gap(s, 3);
            end
        end

        // tx_en drops during data bit 2 of 0x3C with two more bytes queued.
        base = rr_cnt0;
        @(posedge clk); #1;
        push(0, 8'h3C, 1'b1);
        push(0, 8'h11, 1'b1);
        push(0, 8'h22, 1'b1);
        fork
            recv(0, 1'b0, 1'b0);
            begin
                seen = 1'b0;
                for (int t = 0; t < 400 && !seen; t++) begin
                    @(negedge clk);
                    if (tx0 == 1'b0) seen = 1'b1;
                end
                repeat (3 * C + 1) @(negedge clk);
                tx_en0 = 1'b0;
            end
        join
        repeat (60) @(negedge clk);
        chk("t4_no_pop_disabled", rr_cnt0 - base, 1);
        chk("t4_line_idle", {30'd0, tx0, busy0}, 32'b10);
        @(posedge clk); #1;
        tx_en0 = 1'b1;
        recv(0, 1'b0, 1'b0);
        gap(0, 3);
        recv(0, 1'b0, 1'b1);
        chk("t4_pops", rr_cnt0 - base, 3);

        // Reset mid-DATA: line snaps high, popped byte is lost.
        base = rr_cnt0;
        @(posedge clk); #1;
        push(0, 8'h5A, 1'b0);
        seen = 1'b0;
        for (int t = 0; t < 400 && !seen; t++) begin
            @(negedge clk);
            if (tx0 == 1'b0) seen = 1'b1;
        end
        repeat (2 * C + 1) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_async_reset", {29'd0, tx0, busy0, rr0}, 32'b100);
        chk("t5_pops_before", rr_cnt0 - base, 1);
        @(posedge clk); #1;
        push(0, 8'h77, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        recv(0, 1'b0, 1'b0);
        chk("t5_single_pop", rr_cnt0 - base, 2);

        // 256-byte stream.
        base = rr_cnt0;
        @(posedge clk); #1;
        for (int b = 0; b < 256; b++) push(0, 8'(b), 1'b1);
        for (int i = 0; i < 256; i++) begin
            recv(0, 1'b0, i != 0);
            if (i < 255) gap(0, 3);
        end
        chk("t6_pops", rr_cnt0 - base, 256);
        chk("t6_sb_drained", sb0.size(), 0);
        chk("t6_parity_inst_pops", rr_cnt1, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Read-side consumer for the 8-bit FIFO. It pops bytes through the FIFO read port (`read_req` / `read_data` / `EMP`) and serialises each one onto a single UART line: start bit, 8 data bits LSB first, optional even parity, one stop bit. It sits between the FIFO's read port and the chip pin. It is the transmit end of the byte stream that producers push into the FIFO write port.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clk cycles per UART bit; legal values ≥ 2.
- `PARITY_EN`, default 0: 1 inserts an even-parity bit between the data bits and the stop bit.

Ports:
- `clk` input 1: single clock. All logic is on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `tx_en` input 1: allows new frames to start. It never aborts a frame already in progress.
- `EMP` input 1: FIFO empty flag, sampled only in IDLE.
- `read_req` output 1: FIFO pop strobe, registered, exactly one cycle wide.
- `read_data` input 8: FIFO read data, valid the cycle after `read_req`.
- `tx` output 1: serial line, idle high, registered.
- `busy` output 1: high in every state except IDLE.

## Operation
States and transitions:
- IDLE → FETCH when `tx_en` = 1 and `EMP` = 0; otherwise remain in IDLE.
- FETCH → LOAD after 1 cycle; `read_req` = 1 during FETCH only.
- LOAD → START after 1 cycle; the shift register captures `read_data`, and the parity bit is computed as the XOR of its 8 bits.
- START (tx = 0) → DATA after `CLKS_PER_BIT` cycles.
- DATA → PARITY or STOP after 8 bits:
  - shift LSB first;
  - 3-bit bit counter;
  - goes to PARITY if `PARITY_EN` = 1, else to STOP.
- PARITY (tx = parity bit) → STOP after `CLKS_PER_BIT` cycles.
- STOP (tx = 1) → IDLE after `CLKS_PER_BIT` cycles.

Counters and widths:
- Baud counter width is `$clog2(CLKS_PER_BIT)`. It resets to 0 on every state entry and flags bit end at `CLKS_PER_BIT-1`.
- Bit counter wraps 7 → 0 on leaving DATA; no other state uses it.

Boundary rules:
- `read_req` is never asserted while `EMP` = 1 is sampled in IDLE, so there is no underflow pop.
- Only one pop is issued per frame.
- `EMP` and `tx_en` are ignored outside IDLE.
- `tx_en` falling mid-frame: the frame completes, then the block waits in IDLE.
- `reset` asserted mid-frame: the state goes to IDLE immediately and `tx` = 1 asynchronously. The byte already popped is dropped, and no extra pop occurs.
- Back-to-back frames: when the FIFO is non-empty at the end of STOP, the next `read_req` follows with a minimal idle gap (see Timing).

## Timing
Reset values: `tx` = 1, `read_req` = 0, `busy` = 0, state = IDLE, counters = 0, shift register = 0.

Per-frame timeline, with IDLE sampling `EMP` = 0 in cycle n:
- `read_req` high in cycle n+1;
- `read_data` captured at the end of cycle n+2;
- `tx` falls in cycle n+3.

Frame length:
- (10 + `PARITY_EN`) × `CLKS_PER_BIT` cycles from the falling edge of `tx` to the end of the stop bit.

Inter-frame gap:
- The line stays high for 3 cycles between the end of the stop bit and the next start bit (IDLE, FETCH, LOAD).

`busy` timing:
- Rises in cycle n+1.
- Falls in the first IDLE cycle after STOP.

## Structure
Package `uart_pkg` contains:
- the state enum: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP;
- `DATA_BITS` = 8;
- the line constants `LINE_IDLE` = 1 and `START_LVL` = 0.

One sub-module, `baud_gen`:
- parameterised by `CLKS_PER_BIT`;
- inputs: `clk`, `reset`, `restart`;
- output: a one-cycle `bit_done` pulse.

The FSM, shift register and bit counter live in `fifo_uart_tx`.

## Test plan
1. `CLKS_PER_BIT` = 4, `PARITY_EN` = 0, push 0xA5:
   - one `read_req` pulse;
   - `tx` = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles;
   - `busy` falls 1 cycle after the stop bit.
2. `PARITY_EN` = 1, push 0xA5 then 0x01:
   - parity bits 0 then 1;
   - frames are 44 cycles each;
   - exactly 3 high cycles between frames.
3. Hold `EMP` = 1 with `tx_en` = 1 for 100 cycles:
   - `read_req` never asserts, `tx` stays 1, `busy` stays 0.
4. Drop `tx_en` during the 3rd data bit of 0x3C with 2 bytes queued:
   - the 0x3C frame completes;
   - no second `read_req` until `tx_en` returns.
5. Assert `reset` mid-DATA:
   - `tx` = 1 immediately;
   - after release with `EMP` = 0, the next frame starts with a fresh single pop.
6. Push 256 bytes 0x00–0xFF:
   - a UART monitor recovers all 256 in order;
   - exactly 256 `read_req` pulses.
